// File: rtl/dehaze_pkg.sv
// Shared types and constants for the dehaze restoration path.
package dehaze_pkg;

  localparam int TINV_W    = 12;
  localparam int TINV_FRAC = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_A,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/restore_delay.sv
// Two-stage valid/sof/last/t_inv shift register with synchronous flush.
module restore_delay
  import dehaze_pkg::*;
#(
  parameter int TINV_W = dehaze_pkg::TINV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_last,
  input  logic [TINV_W-1:0] in_tinv,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_last,
  output logic [TINV_W-1:0] out_tinv
);

  // Flag vectors are {valid, sof, last}; sidebands drop with valid.
  logic [2:0]        s1_flags_q, s2_flags_q;
  logic [TINV_W-1:0] s1_tinv_q, s2_tinv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_flags_q <= '0;
      s2_flags_q <= '0;
      s1_tinv_q  <= '0;
      s2_tinv_q  <= '0;
    end else if (flush) begin
      s1_flags_q <= '0;
      s2_flags_q <= '0;
    end else begin
      s2_flags_q <= s1_flags_q;
      s2_tinv_q  <= s1_tinv_q;
      if (in_valid) begin
        s1_flags_q <= {1'b1, in_sof, in_last};
        s1_tinv_q  <= in_tinv;
      end else begin
        s1_flags_q <= '0;
      end
    end
  end

  assign out_valid = s2_flags_q[2];
  assign out_sof   = s2_flags_q[1];
  assign out_last  = s2_flags_q[0];
  assign out_tinv  = s2_tinv_q;

endmodule

// File: rtl/restoration_sched.sv
// Frame sequencer feeding the restoration datapath one pixel per cycle.
// Optional t_inv ceiling clamp enabled by defining RESTORE_TINV_CLAMP_EN.
module restoration_sched
  import dehaze_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int TINV_W   = dehaze_pkg::TINV_W,
  parameter int TINV_MAX = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              gray_mode,
  input  logic              a_valid,
  input  logic [7:0]        a_r,
  input  logic [7:0]        a_g,
  input  logic [7:0]        a_b,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [7:0]        pix_r,
  input  logic [7:0]        pix_g,
  input  logic [7:0]        pix_b,
  input  logic [TINV_W-1:0] pix_tinv,
  output logic              dp_en,
  output logic [7:0]        dp_er,
  output logic [7:0]        dp_eg,
  output logic [7:0]        dp_eb,
  output logic [7:0]        dp_ar,
  output logic [7:0]        dp_ag,
  output logic [7:0]        dp_ab,
  output logic [TINV_W-1:0] dp_tinv,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0]     COL_END   = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_END   = RW'(IMG_H - 1);
  localparam logic [TINV_W-1:0] TINV_CEIL = TINV_W'(TINV_MAX);
`ifdef RESTORE_TINV_CLAMP_EN
  localparam logic CLAMP_EN = 1'b1;
`else
  localparam logic CLAMP_EN = 1'b0;
`endif

  state_t            state_q;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              drain_q;
  pixel_t            dp_e_q, dp_a_q;
  logic              dp_en_q;
  logic              accept, first_pix, last_pix;
  logic [TINV_W-1:0] tinv_s1;

  // Abort overrides a same-cycle accept so a half-taken pixel never enters the pipe.
  always_comb begin
    accept    = pix_valid && (state_q == RUN) && !abort;
    first_pix = (col_q == '0) && (row_q == '0);
    last_pix  = (col_q == COL_END) && (row_q == ROW_END);
    col_d     = col_q;
    row_d     = row_q;
    if (accept) begin
      if (col_q == COL_END) begin
        col_d = '0;
        row_d = last_pix ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    tinv_s1 = (CLAMP_EN && (pix_tinv > TINV_CEIL)) ? TINV_CEIL : pix_tinv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= 1'b0;
      dp_e_q  <= '0;
      dp_a_q  <= '0;
      dp_en_q <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept) dp_e_q <= {pix_r, pix_g, pix_b};
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= WAIT_A;
          col_q   <= '0;
          row_q   <= '0;
        end
        WAIT_A: if (a_valid) begin
          dp_a_q  <= {a_r, a_g, a_b};
          dp_en_q <= gray_mode;
          state_q <= RUN;
        end
        RUN: if (accept && last_pix) begin
          state_q <= DRAIN;
          drain_q <= 1'b0;
        end
        DRAIN: begin
          if (drain_q) state_q <= DONE;
          drain_q <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  restore_delay #(.TINV_W(TINV_W)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .in_valid (accept),
    .in_sof   (first_pix),
    .in_last  (last_pix),
    .in_tinv  (tinv_s1),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_last (out_last),
    .out_tinv (dp_tinv)
  );

  assign pix_ready  = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign dp_en      = dp_en_q;
  assign dp_er      = dp_e_q.r;
  assign dp_eg      = dp_e_q.g;
  assign dp_eb      = dp_e_q.b;
  assign dp_ar      = dp_a_q.r;
  assign dp_ag      = dp_a_q.g;
  assign dp_ab      = dp_a_q.b;

endmodule

// File: doc/restoration_sched.md
Name: restoration_sched

Overview:
Frame-level sequencer that feeds the restoration datapath (`restoration`) one pixel per cycle.
- Latches the per-frame atmospheric light A and the grey-mode select, and registers the incoming hazy pixel.
- Delays t_inv so it meets the datapath's internal difference register.
- Generates output valid, start-of-frame and last-pixel markers aligned with O_R/O_G/O_B.
- Sits between the transmission-estimation stage (source of pixel + t_inv) and the output writer.

Parameters:
- IMG_W, 640, pixels per row.
- IMG_H, 480, rows per frame.
- TINV_W, 12, t_inv width; unsigned, 3 fractional bits (value/8), matches datapath.
- TINV_MAX, 80, clamp ceiling for t_inv (10.0, i.e. t_min = 0.1); used only with the optional feature.

Ports:
- clk, input, 1, single clock; all state on posedge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, pulse: begin a frame; honoured only in IDLE.
- abort, input, 1, synchronous: return to IDLE and flush, from any state.
- gray_mode, input, 1, sampled with A; drives dp_en for the whole frame.
- a_valid, input, 1, A triple valid; sampled only in WAIT_A.
- a_r, a_g, a_b, input, 8 each, atmospheric light.
- pix_valid, input, 1, source pixel valid.
- pix_ready, output, 1, combinational: state==RUN.
- pix_r, pix_g, pix_b, input, 8 each, hazy pixel.
- pix_tinv, input, TINV_W, inverse transmission for this pixel.
- dp_en, output, 1, to datapath en.
- dp_er, dp_eg, dp_eb, output, 8 each, to datapath er/eg/eb.
- dp_ar, dp_ag, dp_ab, output, 8 each, to datapath A*_local; held constant per frame.
- dp_tinv, output, TINV_W, to datapath t_inv.
- out_valid, output, 1, datapath outputs O_* valid this cycle.
- out_sof, output, 1, with out_valid: first pixel of frame.
- out_last, output, 1, with out_valid: final pixel of frame.
- busy, output, 1, state != IDLE.
- frame_done, output, 1, one-cycle pulse on DONE.

Behaviour:
- Reset (async): state=IDLE; all outputs, counters, delay stages and dp_* registers = 0.
- States and transitions:
  - IDLE: on start go to WAIT_A.
  - WAIT_A: on a_valid, latch a_r/a_g/a_b into dp_ar/dp_ag/dp_ab and gray_mode into dp_en, then go to RUN.
  - RUN: on accept of pixel IMG_W*IMG_H-1 go to DRAIN.
  - DRAIN: 2 cycles, then go to DONE.
  - DONE: 1 cycle with frame_done=1, then go to IDLE.
- abort: synchronous, highest priority after rst. Next state IDLE; clears the valid delay line, col, row; out_valid is 0 from the next cycle. dp_* data registers are left unchanged.
- Accept = pix_valid & pix_ready. There is no downstream backpressure; the output consumer must take every out_valid cycle.
- On accept at edge k:
  - dp_er/eg/eb <= pix_*.
  - Stage-1 tinv/valid/sof/last <= pix_tinv, 1, (col==0&&row==0), (col==IMG_W-1&&row==IMG_H-1).
  - At edge k+1, stage 2 <= stage 1, and the datapath register captures the difference.
  - dp_tinv, out_valid, out_sof and out_last are driven from stage 2, so they are valid in the cycle after edge k+1 (latency 2 edges, aligned with O_*).
- With no accept, stage-1 valid <= 0. Data registers hold their values.
- Counters:
  - col counts 0..IMG_W-1 and increments on accept.
  - At IMG_W-1 col wraps to 0 and row increments.
  - Both clear on entry to WAIT_A.
- dp_ar/ag/ab/en change only in WAIT_A, when the pipeline is guaranteed empty; there is no mid-frame A update.
- a_valid outside WAIT_A, and start outside IDLE, are ignored.
- pix_valid outside RUN is not accepted (pix_ready=0).
- Same-cycle accept of the last pixel and abort: abort wins, and out_last is never emitted.
- IMG_W=1 or IMG_H=1 must work: sof and last may be on the same pixel.

Optional Feature:
- Macro `RESTORE_TINV_CLAMP_EN`.
- Defined: stage-1 tinv <= min(pix_tinv, TINV_MAX), bounding noise amplification in dense haze.
- Undefined: pix_tinv passes through unmodified and TINV_MAX is unused.

Decomposition:
- Shared package `dehaze_pkg`:
  - state enum {IDLE, WAIT_A, RUN, DRAIN, DONE};
  - TINV_W and TINV_FRAC=3 constants;
  - pixel struct {r, g, b}.
- One sub-module, `restore_delay`: 2-stage valid+sideband+tinv shift register with synchronous flush. It is instantiated once.

Test Plan:
- IMG_W=4, IMG_H=2, start, A=(200,150,100), gray=0, 8 back-to-back pixels with tinv=16:
  - dp_ar=200, dp_en=0;
  - out_valid high 8 consecutive cycles starting 2 cycles after the first accept;
  - out_sof on the first of these, out_last on the 8th;
  - frame_done pulses 3 cycles after out_last's accept.
- With the datapath instanced, er=100, Ar=200, tinv=16 -> O_R=0 on its out_valid cycle; er=180, tinv=8 -> O_R=180.
- pix_valid toggling 1,0,1,0: out_valid reproduces the same gap pattern delayed 2 cycles; col/row advance only on accepts.
- gray=1, A=(90,10,20): dp_en=1 for the whole frame; start pulsed during RUN is ignored; busy stays 1.
- abort asserted after the 3rd accept: IDLE next cycle; out_valid=0 from the following cycle; no out_last; no frame_done. A new start then runs a full frame with out_sof on its first pixel.
- rst asserted asynchronously mid-RUN: all outputs 0 immediately.
- With `RESTORE_TINV_CLAMP_EN`: pix_tinv=200 gives dp_tinv=80. Without it: dp_tinv=200.
